// File: rtl/ahb_dma_write_master.sv
// AHB-Lite write master: one DMA request becomes a single INCR write burst carrying an
// incrementing data pattern to descending word addresses.
// Optional feature macro: DMA_BUSY_INSERT_EN inserts one BUSY cycle after every BUSY_GAP
// accepted beats when more beats remain.
module ahb_dma_write_master #(
  parameter int unsigned BUSY_GAP = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [5:0]  RCC_Words_N,
  input  logic [15:0] RCC_DMA_ADDR_HIGH,
  input  logic [15:0] RCC_DMA_ADDR_LOW,
  input  logic [31:0] init_data,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  if ((BUSY_GAP < 1) || (BUSY_GAP > 63)) begin : gen_gap_check
    $error("BUSY_GAP must be in 1..63");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BURST, S_LAST, S_DONE, S_ERR, S_BUSY
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  n_q, n_d;
  logic [5:0]  beat_q, beat_d;       // index of the beat currently in its address phase
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] d0_q, d0_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [1:0]  htrans;
  logic        last_beat;
  logic        accept;
  logic        in_xfer;
  logic        err_first;
  logic        take_busy;

  assign last_beat = (beat_q == (n_q - 6'd1));
  assign accept    = ((state_q == S_ADDR) || (state_q == S_BURST)) && HREADY;
  assign in_xfer   = (state_q == S_ADDR) || (state_q == S_BURST) ||
                     (state_q == S_LAST) || (state_q == S_BUSY);
  // First cycle of the two-cycle ERROR response.
  assign err_first = in_xfer && HRESP && !HREADY;

`ifdef DMA_BUSY_INSERT_EN
  localparam logic [5:0] GapW = 6'(BUSY_GAP);

  logic [5:0] gap_q, gap_d;

  assign take_busy = ((gap_q + 6'd1) == GapW) && !last_beat;

  // Count accepted beats since the last BUSY; cleared while idle.
  always_comb begin
    gap_d = gap_q;
    if (state_q == S_IDLE) begin
      gap_d = '0;
    end else if (accept) begin
      gap_d = take_busy ? 6'd0 : gap_q + 6'd1;
    end
  end

  // Beat-gap counter register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign take_busy = 1'b0;
`endif

  // Next-state, pipeline registers and bus outputs.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    beat_d   = beat_q;
    haddr_d  = haddr_q;
    d0_d     = d0_q;
    hwdata_d = hwdata_q;
    htrans   = TransIdle;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (RCC_Words_N != 6'd0) begin
            n_d     = RCC_Words_N;
            haddr_d = {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW};
            d0_d    = init_data;
            beat_d  = '0;
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR, S_BURST: begin
        htrans = (state_q == S_ADDR) ? TransNonseq : TransSeq;
        busy   = 1'b1;
        if (HREADY) begin
          // Address accepted: its data goes out next cycle, next address descends.
          haddr_d  = haddr_q - 32'd1;
          hwdata_d = d0_q + {26'd0, beat_q};
          beat_d   = beat_q + 6'd1;
          if (last_beat) begin
            state_d = S_LAST;
          end else if (take_busy) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_BURST;
          end
        end
      end
      S_BUSY: begin
        htrans = TransBusy;
        busy   = 1'b1;
        if (HREADY) begin
          state_d = S_BURST;
        end
      end
      S_LAST: begin
        busy = 1'b1;
        if (HREADY) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Cancel the pending address as soon as the slave signals ERROR.
    if (err_first) begin
      htrans  = TransIdle;
      state_d = S_ERR;
    end
  end

  // State and datapath registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      beat_q   <= '0;
      haddr_q  <= '0;
      d0_q     <= '0;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      beat_q   <= beat_d;
      haddr_q  <= haddr_d;
      d0_q     <= d0_d;
      hwdata_q <= hwdata_d;
    end
  end

  assign HTRANS = htrans;
  assign HADDR  = haddr_q;
  assign HWDATA = hwdata_q;
  assign HWRITE = (htrans != TransIdle);
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b001;

endmodule

// File: tb/tb_ahb_dma_write_master.sv
// Scoreboard bench for ahb_dma_write_master: the driver derives expected bus beats, data
// and completion events from the transfer parameters; a monitor compares them on the bus.
module tb_ahb_dma_write_master;

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

`ifdef DMA_BUSY_INSERT_EN
  localparam int TbGap  = 2;
  localparam bit BusyOn = 1'b1;
`else
  localparam int TbGap  = 4;
  localparam bit BusyOn = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  RCC_Words_N = '0;
  logic [15:0] RCC_DMA_ADDR_HIGH = '0;
  logic [15:0] RCC_DMA_ADDR_LOW = '0;
  logic [31:0] init_data = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        busy;
  logic        done;
  logic        err;

  ahb_dma_write_master #(.BUSY_GAP(TbGap)) dut (
    .HCLK              (HCLK),
    .HRESET            (HRESET),
    .start             (start),
    .RCC_Words_N       (RCC_Words_N),
    .RCC_DMA_ADDR_HIGH (RCC_DMA_ADDR_HIGH),
    .RCC_DMA_ADDR_LOW  (RCC_DMA_ADDR_LOW),
    .init_data         (init_data),
    .HREADY            (HREADY),
    .HRESP             (HRESP),
    .HTRANS            (HTRANS),
    .HADDR             (HADDR),
    .HWRITE            (HWRITE),
    .HSIZE             (HSIZE),
    .HBURST            (HBURST),
    .HWDATA            (HWDATA),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  tr;
    logic [31:0] addr;
  } trans_t;

  typedef struct {
    bit is_err;
    int lat;
  } evt_t;

  trans_t      exp_trans[$];
  logic [31:0] exp_data[$];
  evt_t        exp_evt[$];

  int n_checks = 0;
  int n_pass = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h, required nothing (cycle %0d)", name, act, cyc);
  endtask

  // Mid-transfer config changes must not affect the running burst.
  task automatic scramble();
    RCC_Words_N       = 6'($urandom);
    RCC_DMA_ADDR_HIGH = 16'($urandom);
    RCC_DMA_ADDR_LOW  = 16'($urandom);
    init_data         = $urandom;
  endtask

  // One transfer. mask bit i stalls transfer cycle i; err_after>0 raises ERROR once that
  // many beats were accepted; rst_at>0 asserts HRESET asynchronously in transfer cycle rst_at.
  task automatic do_xfer(input int n, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [63:0] mask, input int err_after, input int rst_at);
    int     items[$];
    int     idx;
    int     i;
    int     stalls;
    int     beats;
    trans_t t;
    evt_t   e;
    for (int k = 0; k < n; k++) begin
      items.push_back(k);
      if (BusyOn && (((k + 1) % TbGap) == 0) && ((k + 1) < n)) items.push_back(-1);
    end
    RCC_Words_N       = 6'(n);
    RCC_DMA_ADDR_HIGH = a0[31:16];
    RCC_DMA_ADDR_LOW  = a0[15:0];
    init_data         = d0;
    HREADY            = 1'b1;
    HRESP             = 1'b0;
    start             = 1'b1;
    start_cyc         = cyc;
    if (n == 0) begin
      e.is_err = 1'b0;
      e.lat    = 1;
      exp_evt.push_back(e);
    end
    @(posedge HCLK); #1;
    start = 1'b0;
    scramble();
    if (n == 0) begin
      @(posedge HCLK); #1;
      return;
    end
    idx    = 0;
    i      = 1;
    stalls = 0;
    beats  = 0;
    while (idx <= items.size()) begin
      if ((rst_at > 0) && (i == rst_at)) begin
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_async_htrans", 32'(HTRANS), 32'(TrIdle));
        chk("rst_async_haddr", HADDR, 32'd0);
        chk("rst_async_hwdata", HWDATA, 32'd0);
        chk("rst_async_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        exp_trans.delete();
        exp_data.delete();
        exp_evt.delete();
        start = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        return;
      end
      if ((err_after > 0) && (beats == err_after)) begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
        start  = ($urandom_range(0, 1) == 1);
        @(posedge HCLK); #1;
        HREADY      = 1'b1;
        HRESP       = 1'b1;
        start       = 1'b1;
        RCC_Words_N = 6'd5;
        e.is_err    = 1'b1;
        e.lat       = idx + stalls + 2;
        exp_evt.push_back(e);
        @(posedge HCLK); #1;
        HRESP = 1'b0;
        start = 1'b0;
        return;
      end
      if ((i < 64) && mask[i]) begin
        HREADY = 1'b0;
        stalls++;
      end else begin
        HREADY = 1'b1;
        if (idx < items.size()) begin
          if (items[idx] < 0) begin
            t.tr   = TrBusy;
            t.addr = a0 - 32'(items[idx-1] + 1);
          end else begin
            t.tr   = (items[idx] == 0) ? TrNonseq : TrSeq;
            t.addr = a0 - 32'(items[idx]);
            if (!((err_after > 0) && (items[idx] == err_after - 1)))
              exp_data.push_back(d0 + 32'(items[idx]));
            beats++;
          end
          exp_trans.push_back(t);
        end
        idx++;
      end
      start = ($urandom_range(0, 3) == 0);
      scramble();
      @(posedge HCLK); #1;
      i++;
    end
    start    = 1'b0;
    e.is_err = 1'b0;
    e.lat    = items.size() + stalls + 2;
    exp_evt.push_back(e);
    @(posedge HCLK); #1;
  endtask

  // Monitor: compares the bus against the scoreboard queues on every falling edge.
  initial begin : monitor
    logic        pend;
    logic        pv;
    logic        p_rdy;
    logic        p_resp;
    logic [1:0]  p_tr;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    trans_t      t;
    evt_t        e;
    logic [31:0] d;
    pend = 1'b0;
    pv   = 1'b0;
    p_rdy = 1'b1; p_resp = 1'b0; p_tr = TrIdle; p_addr = '0; p_data = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        pend = 1'b0;
        pv   = 1'b0;
      end else begin
        if (pv && !p_rdy && !p_resp && !HRESP) begin
          chk("hold_htrans", 32'(HTRANS), 32'(p_tr));
          chk("hold_haddr", HADDR, p_addr);
          chk("hold_hwdata", HWDATA, p_data);
        end
        if (HRESP && !HREADY) begin
          chk("err_cancel_htrans", 32'(HTRANS), 32'(TrIdle));
          chk("err_cancel_hwrite", 32'(HWRITE), 32'd0);
        end
        if (pend && HREADY) begin
          pend = 1'b0;
          if (!HRESP) begin
            if (exp_data.size() == 0) unexpected("hwdata_extra", HWDATA);
            else begin
              d = exp_data.pop_front();
              chk("hwdata", HWDATA, d);
            end
          end
        end
        if (HREADY && !HRESP && (HTRANS != TrIdle)) begin
          if (exp_trans.size() == 0) unexpected("htrans_extra", 32'(HTRANS));
          else begin
            t = exp_trans.pop_front();
            chk("htrans", 32'(HTRANS), 32'(t.tr));
            chk("haddr", HADDR, t.addr);
          end
          chk("hwrite", 32'(HWRITE), 32'd1);
          chk("hsize", 32'(HSIZE), 32'd2);
          chk("hburst", 32'(HBURST), 32'd1);
          if ((HTRANS == TrNonseq) || (HTRANS == TrSeq)) pend = 1'b1;
        end
        if (HTRANS != TrIdle) chk("busy_active", 32'(busy), 32'd1);
        if (done || err) begin
          chk("busy_at_end", 32'(busy), 32'd0);
          if (exp_evt.size() == 0) unexpected("end_extra", {30'd0, err, done});
          else begin
            e = exp_evt.pop_front();
            chk("end_err", 32'(err), 32'(e.is_err));
            chk("end_done", 32'(done), 32'(!e.is_err));
            chk("end_latency", 32'(cyc - start_cyc), 32'(e.lat));
          end
        end
        pv     = 1'b1;
        p_rdy  = HREADY;
        p_resp = HRESP;
        p_tr   = HTRANS;
        p_addr = HADDR;
        p_data = HWDATA;
      end
    end
  end

  initial begin : stim
    int          n;
    int          ea;
    logic [63:0] m;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("reset_htrans", 32'(HTRANS), 32'(TrIdle));
    chk("reset_haddr", HADDR, 32'd0);
    chk("reset_hwdata", HWDATA, 32'd0);
    chk("reset_hwrite", 32'(HWRITE), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done_err", {30'd0, err, done}, 32'd0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    do_xfer(4, 32'h0000_0100, 32'h0000_00A5, 64'd0, 0, 0);
    do_xfer(3, 32'h2000_0040, 32'h1234_5678, 64'h18, 0, 0);
    do_xfer(0, 32'hDEAD_BEEF, 32'h0000_0001, 64'd0, 0, 0);
    do_xfer(1, 32'h0000_0000, 32'hFFFF_FFFF, 64'd0, 0, 0);
    do_xfer(3, 32'h0000_0001, 32'hFFFF_FFFE, 64'd0, 0, 0);
    do_xfer(6, 32'h8000_0000, 32'h0000_0010, 64'd0, 3, 0);
    do_xfer(6, 32'h8000_0000, 32'h0000_0010, 64'd0, 0, 0);
    do_xfer(10, 32'h0000_0300, 32'h0000_0007, 64'd0, 0, 4);
    do_xfer(5, 32'h0000_0400, 32'h0000_0050, 64'd0, 0, 0);
    chk("hwdata_retained", HWDATA, 32'h0000_0054);

    for (int r = 0; r < 30; r++) begin
      n  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 8);
      m  = {$urandom, $urandom} & {$urandom, $urandom};
      ea = ((n > 0) && ($urandom_range(0, 4) == 0)) ? $urandom_range(1, n) : 0;
      do_xfer(n, $urandom, $urandom, m, ea, 0);
    end

    repeat (3) @(posedge HCLK);
    #1;
    chk("trans_queue_drained", 32'(exp_trans.size()), 32'd0);
    chk("data_queue_drained", 32'(exp_data.size()), 32'd0);
    chk("event_queue_drained", 32'(exp_evt.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_dma_write_master.md
Name: ahb_dma_write_master

Overview:
- AHB-Lite master that turns one RCC DMA write request into a single undefined-length write burst.
- The burst carries an incrementing data pattern to descending word addresses.
- Sits directly upstream of the memory slave and the write checker; its HTRANS/HADDR/HWDATA are what the checker's expected-data/address model tracks.
- Config comes from RCC registers; start is a single-cycle pulse from the RCC block.

Parameters:
- BUSY_GAP, 4, beats between inserted BUSY cycles (used only with DMA_BUSY_INSERT_EN; legal range 1..63)

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in S_IDLE
- RCC_Words_N  in  6  number of words to write
- RCC_DMA_ADDR_HIGH  in  16  start address [31:16]
- RCC_DMA_ADDR_LOW  in  16  start address [15:0]
- init_data  in  32  data of first beat
- HREADY  in  1  slave ready
- HRESP  in  1  0=OKAY, 1=ERROR
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11 (ahb3lite_pkg HTRANS_state)
- HADDR  out  32  address phase
- HWRITE  out  1  1 during NONSEQ/SEQ/BUSY, else 0
- HSIZE  out  3  fixed 3'b010 (word)
- HBURST  out  3  fixed 3'b001 (INCR)
- HWDATA  out  32  data phase
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse on ERROR abort

Behaviour:
- Reset (async, HRESET=1): state S_IDLE; HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, err=0; beat counters cleared. Reset mid-burst aborts immediately, with no completion pulse.
- start in S_IDLE with RCC_Words_N>0 latches the following and sets busy next cycle: N, A0={HIGH,LOW}, D0=init_data.
- Latched values are held for the whole transfer; RCC changes mid-burst have no effect.
- start while busy is ignored.
- start with RCC_Words_N=0: no bus activity; done pulses in the next cycle; busy stays 0.
- States:
  - S_IDLE
  - S_ADDR: first address phase, HTRANS=NONSEQ, HADDR=A0.
  - S_BURST: beat k (k=1..N-1): HTRANS=SEQ, HADDR=A0-k (32-bit wraparound, modulo 2^32).
  - S_LAST: HTRANS=IDLE, final data phase pending.
  - S_DONE: one cycle, done=1, then S_IDLE.
- Pipeline:
  - Address phase of beat k completes on the HCLK edge where HREADY=1.
  - From the following cycle, HWDATA=D0+k (32-bit wraparound) until its data phase completes with HREADY=1.
  - While HREADY=0, HTRANS/HADDR/HWDATA hold.
- N=1: S_ADDR goes straight to S_LAST.
- S_LAST leaves on HREADY=1.
- Exactly N NONSEQ/SEQ beats per transfer. Transfer latency with zero wait states: start edge to done = N+2 cycles.
- HRESP=ERROR (two-cycle response), first cycle, HREADY=0: drive HTRANS=IDLE in the same cycle (combinational override), cancelling the pending address.
- HRESP=ERROR, second cycle: pulse err, drop busy, return to S_IDLE. done is not asserted.
- ERROR and a new start in the same cycle: start is ignored (not in S_IDLE).
- HWDATA retains the last value after completion; it is only reset by HRESET.

Optional Feature:
- DMA_BUSY_INSERT_EN defined:
  - After every BUSY_GAP accepted beats, if beats remain, insert one BUSY cycle before the next SEQ.
  - During BUSY: HADDR=next beat address, HWRITE=1; the data phase of the previous beat proceeds normally.
  - No BUSY is inserted after the final beat.
- Undefined: no BUSY is ever issued; the BUSY_GAP parameter is unused.

Test Plan:
- N=4, A0=0x0000_0100, D0=0xA5: zero wait.
  - HADDR 0x100,0xFF,0xFE,0xFD.
  - HWDATA 0xA5..0xA8, each one cycle after its address.
  - HTRANS NONSEQ,SEQ,SEQ,SEQ,IDLE; done 6 cycles after start.
- N=3, HREADY low 2 cycles during beat 1 data phase: HADDR/HWDATA/HTRANS held stable; all 3 beats still delivered; done delayed by 2 cycles.
- N=0 start: HTRANS stays IDLE; done pulses next cycle; busy never 1. N=1, A0=0, D0=0xFFFF_FFFF: single NONSEQ at 0x0, HWDATA=0xFFFF_FFFF.
- Wraparound: N=3, A0=0x1, D0=0xFFFF_FFFE gives addresses 0x1,0x0,0xFFFF_FFFF and data 0xFFFF_FFFE,0xFFFF_FFFF,0x0.
- HRESP ERROR on beat 2 of N=6: HTRANS goes IDLE in the first ERROR cycle; err pulses; no done; the next start succeeds normally. HRESET asserted mid-burst: all outputs reset at once, asynchronously.
- With DMA_BUSY_INSERT_EN, BUSY_GAP=2, N=5: HTRANS NONSEQ,SEQ,BUSY,SEQ,SEQ,BUSY,SEQ,IDLE. Without the macro: no BUSY.
